// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encoding,
// register-address width and the control-word payload.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BUB_CNT_W  = 2;

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic if_flush;
        logic idex_bubble;
        logic exmem_hold;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX operand info, branch and memory
// status in; pipeline enables and performance counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_busy;

    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IF_flush;
    logic                  IDEX_bubble;
    logic                  EXMEM_hold;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        input  PCWrite, IFIDWrite, IF_flush, IDEX_bubble, EXMEM_hold,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        output PCWrite, IFIDWrite, IF_flush, IDEX_bubble, EXMEM_hold,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= W'(0);
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: load-use bubbles, taken-branch flush and
// data-memory freeze, with saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam logic [BUB_CNT_W-1:0] BUB_LOAD = BUB_CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam bit                   MULTI_BUB = (LOAD_USE_BUBBLES > 1);

    hz_state_e             r_state;
    hz_state_e             r_saved_state;
    logic [BUB_CNT_W-1:0]  r_bub_cnt;

    hz_state_e             w_next_state;
    hz_state_e             w_next_saved;
    hz_state_e             w_eff_state;
    logic [BUB_CNT_W-1:0]  w_next_bub_cnt;
    logic                  w_lu_hazard;
    logic                  w_flush_inc;
    hz_ctrl_t              w_ctrl;
    logic [CNT_W-1:0]      w_stall_cnt;
    logic [CNT_W-1:0]      w_flush_cnt;

    assign w_lu_hazard = bus.ex_mem_read && (bus.ex_rd != X0) &&
                         ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                          (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    // While frozen, behave as the state that was interrupted by the busy memory.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_saved_state : r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_saved_state <= RUN;
            r_bub_cnt     <= BUB_CNT_W'(0);
        end else begin
            r_state       <= w_next_state;
            r_saved_state <= w_next_saved;
            r_bub_cnt     <= w_next_bub_cnt;
        end
    end

    always_comb begin
        w_ctrl         = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
        w_next_state   = w_eff_state;
        w_next_saved   = r_saved_state;
        w_next_bub_cnt = r_bub_cnt;
        w_flush_inc    = 1'b0;

        if (reset) begin
            w_ctrl = '{if_flush: 1'b1, idex_bubble: 1'b1, default: 1'b0};
        end else if (bus.mem_busy) begin
            w_ctrl       = '{exmem_hold: 1'b1, default: 1'b0};
            w_next_state = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_next_saved = r_state;
            end
        end else if (bus.branch_taken) begin
            w_ctrl         = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b1,
                               idex_bubble: 1'b1, default: 1'b0};
            w_next_state   = RUN;
            w_next_bub_cnt = BUB_CNT_W'(0);
            w_flush_inc    = 1'b1;
        end else if (w_eff_state == LU_STALL) begin
            w_ctrl         = '{idex_bubble: 1'b1, default: 1'b0};
            w_next_bub_cnt = r_bub_cnt - BUB_CNT_W'(1);
            if (r_bub_cnt <= BUB_CNT_W'(1)) begin
                w_next_state = RUN;
            end
        end else if (w_lu_hazard) begin
            w_ctrl = '{idex_bubble: 1'b1, default: 1'b0};
            // A single-bubble configuration never leaves RUN.
            if (MULTI_BUB) begin
                w_next_state   = LU_STALL;
                w_next_bub_cnt = BUB_LOAD;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (!w_ctrl.pc_write),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush_inc),
        .o_count (w_flush_cnt)
    );

    assign bus.PCWrite      = w_ctrl.pc_write;
    assign bus.IFIDWrite    = w_ctrl.ifid_write;
    assign bus.IF_flush     = w_ctrl.if_flush;
    assign bus.IDEX_bubble  = w_ctrl.idex_bubble;
    assign bus.EXMEM_hold   = w_ctrl.exmem_hold;
    assign bus.stall_cycles = w_stall_cnt;
    assign bus.flush_count  = w_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard controller for the five-stage pipeline. It drives the fetch-stage PCWrite, the IF/ID register's IFIDWrite and IF_flush, and a bubble-insert for ID/EX. It resolves three hazards: load-use (a multi-cycle bubble sequence), taken-branch redirect, and data-memory busy (a full freeze). It also keeps saturating stall and flush performance counters.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3).
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high
id_rs1  input  5  source register 1 of the instruction in ID
id_rs2  input  5  source register 2 of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of the instruction in EX
ex_mem_read  input  1  EX instruction is a load
branch_taken  input  1  EX resolved a taken branch or jump this cycle
mem_busy  input  1  data memory not ready; MEM must hold
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IF_flush  output  1  zero the IF/ID register
IDEX_bubble  output  1  load a NOP into ID/EX
EXMEM_hold  output  1  hold the EX/MEM and MEM/WB registers
stall_cycles  output  CNT_W  cycles in which PCWrite==0
flush_count  output  CNT_W  taken-branch flushes performed

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
- While reset is high: PCWrite=0, IFIDWrite=0, IF_flush=1, IDEX_bubble=1, EXMEM_hold=0.
- After the reset edge: state=RUN, bubble counter=0, stall_cycles=0, flush_count=0.
- States: RUN, LU_STALL, MEM_WAIT. Outputs are combinational from state and inputs (Mealy). State, counters and perf counters are registered.
- lu_hazard = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Output priority per cycle:
  1. mem_busy: PCWrite=0, IFIDWrite=0, IF_flush=0, IDEX_bubble=0, EXMEM_hold=1. State goes to MEM_WAIT; the bubble counter is frozen.
  2. branch_taken: PCWrite=1, IFIDWrite=1, IF_flush=1, IDEX_bubble=1, EXMEM_hold=0. State goes to RUN, the bubble counter clears, and flush_count increments.
  3. lu_hazard in RUN, or state==LU_STALL: PCWrite=0, IFIDWrite=0, IF_flush=0, IDEX_bubble=1.
  4. Otherwise: PCWrite=1, IFIDWrite=1, others 0.
- RUN -> LU_STALL on lu_hazard when LOAD_USE_BUBBLES>1; the counter loads LOAD_USE_BUBBLES-1. With LOAD_USE_BUBBLES==1, state stays RUN; the single bubble comes from the combinational path.
- LU_STALL: the counter decrements each non-busy cycle. When it reaches 1 and decrements, the next state is RUN. lu_hazard is ignored here because the bubble already moved the load on.
- MEM_WAIT: held while mem_busy. On release, return to the state saved on entry (RUN or LU_STALL with its counter intact).
- A branch_taken held during a busy cycle is acted on in the first cycle after mem_busy falls.
- Simultaneous branch_taken and lu_hazard: the branch wins. No bubble sequence starts.
- stall_cycles increments on every post-reset cycle with PCWrite==0. Both perf counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-busy: the state machine returns to RUN on that edge and outputs take their reset values immediately.

Decomposition:
- Shared pipeline package: state encoding (2-bit localparams RUN=0, LU_STALL=1, MEM_WAIT=2), REG_ADDR_W=5, and the x0 constant.
- One natural sub-module, sat_counter (width parameter, synchronous reset, inc enable). It is instantiated twice, for the two perf counters.

Test Plan:
- Reset held 3 cycles, then released → PCWrite=0/IF_flush=1/IDEX_bubble=1 during reset; both counters read 0 after release; PCWrite=1 on the first idle cycle.
- LOAD_USE_BUBBLES=1, lw x5 in EX with ID add reading x5 → exactly one cycle of PCWrite=0, IFIDWrite=0, IDEX_bubble=1; stall_cycles=1.
- LOAD_USE_BUBBLES=3, same hazard → 3 consecutive bubble cycles, then RUN; stall_cycles=3. A load with ex_rd=0 → no stall.
- branch_taken pulse with a concurrent load-use hazard → IF_flush=1, IDEX_bubble=1, PCWrite=1 in the same cycle; no stall follows; flush_count=1.
- mem_busy for 4 cycles during the second cycle of a 3-bubble stall → EXMEM_hold=1 and all enables 0 for 4 cycles; afterwards exactly 1 remaining bubble; stall_cycles=7.
- Force stall_cycles to near saturation (CNT_W=4) and stall 20 cycles → the counter reads 15 and holds there.
